// File: rtl/capture_sequencer.sv
// capture_sequencer: shadowed crop windows committed in vertical blanking, settling-frame skip,
// JPEG start pulse and completion tracking. Optional abort timeout: define CAPTURE_TIMEOUT_EN.
module capture_sequencer #(
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        config_valid_in,
  input  logic [43:0] pan_window_in,
  input  logic [43:0] zoom_window_in,
  input  logic [1:0]  skip_frames_in,
  input  logic        start_capture_in,
  input  logic        frame_valid_in,
  input  logic        image_complete_in,
  output logic [43:0] pan_window_out,
  output logic [43:0] zoom_window_out,
  output logic [10:0] x_size_out,
  output logic [10:0] y_size_out,
  output logic        start_capture_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [1:0]  error_out
);

  // state   | meaning
  // IDLE    | waiting for a start_capture_in rising edge
  // SKIP    | discarding settling frames, one per frame-end
  // ARM     | waiting for blanking with no window update pending
  // CAPTURE | encoder running, active windows frozen
  // DONE    | image complete, waiting for start_capture_in to drop
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SKIP    = 3'd1,
    S_ARM     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [43:0] PAN_RST  = {11'd284, 11'd1004, 11'd4, 11'd724};
  localparam logic [43:0] ZOOM_RST = {11'd260, 11'd460, 11'd260, 11'd460};
  localparam logic [10:0] SIZE_RST = 11'd200;

  state_t      state_q, state_d;
  logic [43:0] pan_act_q, pan_act_d;
  logic [43:0] zoom_act_q, zoom_act_d;
  logic [43:0] pan_shd_q, pan_shd_d;
  logic [43:0] zoom_shd_q, zoom_shd_d;
  logic        pending_q, pending_d;
  logic [10:0] x_size_q, x_size_d;
  logic [10:0] y_size_q, y_size_d;
  logic        err_cfg_q, err_cfg_d;
  logic        start_pulse_q, start_pulse_d;
  logic [1:0]  skip_cnt_q, skip_cnt_d;
  logic        fv_q, fv_d;
  logic        start_prev_q, start_prev_d;
  logic        ic_prev_q, ic_prev_d;
  logic        ic_rise_q, ic_rise_d;

`ifdef CAPTURE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_FRAMES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_to_q, err_to_d;
`endif

  logic        start_rise;
  logic        frame_end;
  logic        commit;
  logic [10:0] pan_x_size, pan_y_size;
  logic [10:0] zoom_x_size, zoom_y_size;
  logic        axes_ordered;
  logic        cfg_legal;

  // Configuration legality, evaluated on the incoming windows
  always_comb begin
    pan_x_size   = pan_window_in[32:22]  - pan_window_in[43:33];
    pan_y_size   = pan_window_in[10:0]   - pan_window_in[21:11];
    zoom_x_size  = zoom_window_in[32:22] - zoom_window_in[43:33];
    zoom_y_size  = zoom_window_in[10:0]  - zoom_window_in[21:11];
    axes_ordered = (pan_window_in[43:33]  < pan_window_in[32:22])  &&
                   (pan_window_in[21:11]  < pan_window_in[10:0])   &&
                   (zoom_window_in[43:33] < zoom_window_in[32:22]) &&
                   (zoom_window_in[21:11] < zoom_window_in[10:0]);
    // 12-bit compare so a one-pixel pan window cannot wrap the -2 margin
    cfg_legal    = axes_ordered &&
                   (({1'b0, zoom_x_size} + 12'd2) <= {1'b0, pan_x_size}) &&
                   (({1'b0, zoom_y_size} + 12'd2) <= {1'b0, pan_y_size});
  end

  always_comb begin
    start_rise   = start_capture_in && !start_prev_q;
    frame_end    = fv_q && !frame_valid_in;
    commit       = pending_q && !frame_valid_in && (state_q != S_CAPTURE);
    fv_d         = frame_valid_in;
    start_prev_d = start_capture_in;
    ic_prev_d    = image_complete_in;
    // Only edges seen while capturing count; a level already high on entry is ignored
    ic_rise_d    = image_complete_in && !ic_prev_q && (state_q == S_CAPTURE);
  end

  // Shadow load, commit with write-through, and size registers
  always_comb begin
    pan_shd_d  = pan_shd_q;
    zoom_shd_d = zoom_shd_q;
    pan_act_d  = pan_act_q;
    zoom_act_d = zoom_act_q;
    pending_d  = pending_q;
    err_cfg_d  = err_cfg_q;

    if (config_valid_in) begin
      if (cfg_legal) begin
        pan_shd_d  = pan_window_in;
        zoom_shd_d = zoom_window_in;
        pending_d  = 1'b1;
        err_cfg_d  = 1'b0;
      end else begin
        err_cfg_d  = 1'b1;
      end
    end

    if (commit) begin
      if (config_valid_in && cfg_legal) begin
        pan_act_d  = pan_window_in;
        zoom_act_d = zoom_window_in;
      end else begin
        pan_act_d  = pan_shd_q;
        zoom_act_d = zoom_shd_q;
      end
      pending_d = 1'b0;
    end

    x_size_d = zoom_act_q[32:22] - zoom_act_q[43:33];
    y_size_d = zoom_act_q[10:0]  - zoom_act_q[21:11];
  end

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    start_pulse_d = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    err_to_d      = err_to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          skip_cnt_d = skip_frames_in;
`ifdef CAPTURE_TIMEOUT_EN
          err_to_d   = 1'b0;
`endif
          state_d    = (skip_frames_in != 2'd0) ? S_SKIP : S_ARM;
        end
      end
      S_SKIP: begin
        if (frame_end) begin
          skip_cnt_d = skip_cnt_q - 2'd1;
          if (skip_cnt_q == 2'd1) state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (!pending_q && !frame_valid_in) begin
          start_pulse_d = 1'b1;
          state_d       = S_CAPTURE;
`ifdef CAPTURE_TIMEOUT_EN
          to_cnt_d      = TO_W'(TIMEOUT_FRAMES);
`endif
        end
      end
      S_CAPTURE: begin
        if (ic_rise_q) begin
          state_d = S_DONE;
        end
`ifdef CAPTURE_TIMEOUT_EN
        else if (frame_end) begin
          if (to_cnt_q == TO_W'(1)) begin
            err_to_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            to_cnt_d = to_cnt_q - TO_W'(1);
          end
        end
`endif
      end
      S_DONE: begin
        if (!start_capture_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q       <= S_IDLE;
      pan_act_q     <= PAN_RST;
      zoom_act_q    <= ZOOM_RST;
      pan_shd_q     <= PAN_RST;
      zoom_shd_q    <= ZOOM_RST;
      pending_q     <= 1'b0;
      x_size_q      <= SIZE_RST;
      y_size_q      <= SIZE_RST;
      err_cfg_q     <= 1'b0;
      start_pulse_q <= 1'b0;
      skip_cnt_q    <= 2'd0;
      fv_q          <= 1'b0;
      start_prev_q  <= 1'b0;
      ic_prev_q     <= 1'b0;
      ic_rise_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pan_act_q     <= pan_act_d;
      zoom_act_q    <= zoom_act_d;
      pan_shd_q     <= pan_shd_d;
      zoom_shd_q    <= zoom_shd_d;
      pending_q     <= pending_d;
      x_size_q      <= x_size_d;
      y_size_q      <= y_size_d;
      err_cfg_q     <= err_cfg_d;
      start_pulse_q <= start_pulse_d;
      skip_cnt_q    <= skip_cnt_d;
      fv_q          <= fv_d;
      start_prev_q  <= start_prev_d;
      ic_prev_q     <= ic_prev_d;
      ic_rise_q     <= ic_rise_d;
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      to_cnt_q <= '0;
      err_to_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_to_q <= err_to_d;
    end
  end

  assign error_out = {err_to_q, err_cfg_q};
`else
  assign error_out = {1'b0, err_cfg_q};
`endif

  assign pan_window_out    = pan_act_q;
  assign zoom_window_out   = zoom_act_q;
  assign x_size_out        = x_size_q;
  assign y_size_out        = y_size_q;
  assign start_capture_out = start_pulse_q;
  assign busy_out          = (state_q == S_SKIP) || (state_q == S_ARM) || (state_q == S_CAPTURE);
  assign done_out          = (state_q == S_DONE);

endmodule
